// File: rtl/cdda_volume.sv
// cdda_volume: CD-DA output stage with port routing, per-output 8-bit volume and mute.
// Optional macro CDDA_VOL_RAMP_EN: current volume ramps toward target by RAMP_STEP per sample.
module cdda_volume #(
    parameter logic [7:0] DEFAULT_VOL = 8'd255,
    parameter logic [7:0] RAMP_STEP   = 8'd4
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        IN_CE,
    input  logic [15:0] IN_L,
    input  logic [15:0] IN_R,
    input  logic        CFG_WR,
    input  logic [1:0]  CFG_ADDR,
    input  logic [7:0]  CFG_DIN,
    output logic [7:0]  CFG_DOUT,
    input  logic        MUTE,
    output logic        OUT_CE,
    output logic [15:0] OUT_L,
    output logic [15:0] OUT_R
);

    logic [7:0]  tgt_l, tgt_r, cur_l, cur_r;
    logic [1:0]  route_l, route_r;
    logic        s1_valid, s2_valid;
    logic [15:0] s1_l, s1_r, s2_l, s2_r;
    logic [7:0]  s1_vol_l, s1_vol_r;

    function automatic logic [15:0] route_sel(input logic [1:0] sel, input logic [15:0] l,
                                               input logic [15:0] r);
        logic signed [16:0] sum;
        logic [15:0]        result;
        sum = $signed({l[15], l}) + $signed({r[15], r});
        case (sel)
            2'b00:   result = 16'd0;
            2'b01:   result = l;
            2'b10:   result = r;
            default: result = 16'(sum >>> 1);
        endcase
        return result;
    endfunction

    // Volume 255 is treated as exact unity rather than 255/256.
    function automatic logic [15:0] apply_gain(input logic [15:0] s, input logic [7:0] v);
        logic signed [24:0] prod;
        prod = $signed(25'($signed(s))) * $signed(25'({1'b0, v}));
        return (v == 8'hFF) ? s : 16'(prod >>> 8);
    endfunction

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            tgt_l   <= DEFAULT_VOL;
            tgt_r   <= DEFAULT_VOL;
            route_l <= 2'b01;
            route_r <= 2'b10;
        end else if (CFG_WR) begin
            case (CFG_ADDR)
                2'd0:    tgt_l   <= CFG_DIN;
                2'd1:    tgt_r   <= CFG_DIN;
                2'd2:    route_l <= CFG_DIN[1:0];
                default: route_r <= CFG_DIN[1:0];
            endcase
        end
    end

`ifdef CDDA_VOL_RAMP_EN
    // The gap is compared at 9 bits so stepping can never wrap the 8-bit current value.
    function automatic logic [7:0] ramp_next(input logic [7:0] cur, input logic [7:0] tgt);
        logic [8:0] gap;
        logic [7:0] result;
        if (tgt > cur) gap = {1'b0, tgt} - {1'b0, cur};
        else           gap = {1'b0, cur} - {1'b0, tgt};
        if (gap <= {1'b0, RAMP_STEP}) result = tgt;
        else if (tgt > cur)           result = cur + RAMP_STEP;
        else                          result = cur - RAMP_STEP;
        return result;
    endfunction

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            cur_l <= DEFAULT_VOL;
            cur_r <= DEFAULT_VOL;
        end else if (IN_CE) begin
            cur_l <= ramp_next(cur_l, tgt_l);
            cur_r <= ramp_next(cur_r, tgt_r);
        end
    end
`else
    assign cur_l = tgt_l;
    assign cur_r = tgt_r;

    logic unused_ramp_step;
    assign unused_ramp_step = ^RAMP_STEP;
`endif

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            s1_valid <= 1'b0;
            s1_l     <= 16'd0;
            s1_r     <= 16'd0;
            s1_vol_l <= 8'd0;
            s1_vol_r <= 8'd0;
        end else begin
            s1_valid <= IN_CE;
            if (IN_CE) begin
                s1_l     <= route_sel(route_l, IN_L, IN_R);
                s1_r     <= route_sel(route_r, IN_L, IN_R);
                s1_vol_l <= cur_l;
                s1_vol_r <= cur_r;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            s2_valid <= 1'b0;
            s2_l     <= 16'd0;
            s2_r     <= 16'd0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_l <= MUTE ? 16'd0 : apply_gain(s1_l, s1_vol_l);
                s2_r <= MUTE ? 16'd0 : apply_gain(s1_r, s1_vol_r);
            end
        end
    end

    // Outputs hold their last value between strobes.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            OUT_CE <= 1'b0;
            OUT_L  <= 16'd0;
            OUT_R  <= 16'd0;
        end else begin
            OUT_CE <= s2_valid;
            if (s2_valid) begin
                OUT_L <= s2_l;
                OUT_R <= s2_r;
            end
        end
    end

    always_comb begin
        CFG_DOUT = 8'd0;
        case (CFG_ADDR)
            2'd0:    CFG_DOUT = tgt_l;
            2'd1:    CFG_DOUT = tgt_r;
            2'd2:    CFG_DOUT = {6'd0, route_l};
            default: CFG_DOUT = {6'd0, route_r};
        endcase
    end

endmodule

// File: tb/tb_cdda_volume.sv
// Self-checking bench for cdda_volume: randomized samples checked against an arithmetic model.
// Honours CDDA_VOL_RAMP_EN the same way the design does.
module tb_cdda_volume;

    localparam int STEP = 4;

    logic        CLK = 1'b0;
    logic        nRESET = 1'b0;
    logic        IN_CE = 1'b0;
    logic [15:0] IN_L = 16'd0;
    logic [15:0] IN_R = 16'd0;
    logic        CFG_WR = 1'b0;
    logic [1:0]  CFG_ADDR = 2'd0;
    logic [7:0]  CFG_DIN = 8'd0;
    logic [7:0]  CFG_DOUT;
    logic        MUTE = 1'b0;
    logic        OUT_CE;
    logic [15:0] OUT_L;
    logic [15:0] OUT_R;

    int errors = 0;
    int checks = 0;

    int m_tgt_l, m_tgt_r, m_cur_l, m_cur_r, m_route_l, m_route_r;
    int m_s1_l, m_s1_r, m_s1_vl, m_s1_vr, m_s2_l, m_s2_r;
    bit m_s1_v, m_s2_v;
    logic        exp_ce;
    logic [15:0] exp_l, exp_r;

    cdda_volume dut (
        .CLK(CLK), .nRESET(nRESET), .IN_CE(IN_CE), .IN_L(IN_L), .IN_R(IN_R),
        .CFG_WR(CFG_WR), .CFG_ADDR(CFG_ADDR), .CFG_DIN(CFG_DIN), .CFG_DOUT(CFG_DOUT),
        .MUTE(MUTE), .OUT_CE(OUT_CE), .OUT_L(OUT_L), .OUT_R(OUT_R)
    );

    always #5 CLK = ~CLK;

    function automatic int floor_div(int a, int b);
        return (a >= 0) ? a / b : -((-a + b - 1) / b);
    endfunction

    function automatic int m_route(int sel, int l, int r);
        case (sel)
            0:       return 0;
            1:       return l;
            2:       return r;
            default: return floor_div(l + r, 2);
        endcase
    endfunction

    function automatic int m_gain(int x, int v);
        return (v == 255) ? x : floor_div(x * v, 256);
    endfunction

    function automatic int m_ramp(int cur, int tgt);
        int d;
        d = tgt - cur;
        if (d <= STEP && d >= -STEP) return tgt;
        return (d > 0) ? cur + STEP : cur - STEP;
    endfunction

    function automatic int m_dout(int addr);
        case (addr)
            0:       return m_tgt_l;
            1:       return m_tgt_r;
            2:       return m_route_l;
            default: return m_route_r;
        endcase
    endfunction

    task automatic mdl_reset();
        m_tgt_l = 255; m_tgt_r = 255; m_cur_l = 255; m_cur_r = 255;
        m_route_l = 1; m_route_r = 2;
        m_s1_v = 0; m_s2_v = 0;
        exp_ce = 1'b0; exp_l = 16'd0; exp_r = 16'd0;
    endtask

    // One clock: drive inputs at the falling edge, advance the model, return 1 after the rising edge.
    task automatic drive(input bit ce, input int l, input int r, input bit wr, input int addr,
                         input int din, input bit mute);
        logic [15:0] l16, r16;
        int sl, sr;
        @(negedge CLK);
        l16 = 16'(l); r16 = 16'(r);
        sl = int'($signed(l16)); sr = int'($signed(r16));
        IN_CE = ce; IN_L = l16; IN_R = r16;
        CFG_WR = wr; CFG_ADDR = 2'(addr); CFG_DIN = 8'(din); MUTE = mute;
        exp_ce = m_s2_v;
        if (m_s2_v) begin
            exp_l = 16'(m_s2_l);
            exp_r = 16'(m_s2_r);
        end
        m_s2_v = m_s1_v;
        if (m_s1_v) begin
            m_s2_l = mute ? 0 : m_gain(m_s1_l, m_s1_vl);
            m_s2_r = mute ? 0 : m_gain(m_s1_r, m_s1_vr);
        end
        m_s1_v = ce;
        if (ce) begin
            m_s1_l  = m_route(m_route_l, sl, sr);
            m_s1_r  = m_route(m_route_r, sl, sr);
            m_s1_vl = m_cur_l;
            m_s1_vr = m_cur_r;
`ifdef CDDA_VOL_RAMP_EN
            m_cur_l = m_ramp(m_cur_l, m_tgt_l);
            m_cur_r = m_ramp(m_cur_r, m_tgt_r);
`endif
        end
        if (wr) begin
            case (addr)
                0:       m_tgt_l   = din & 255;
                1:       m_tgt_r   = din & 255;
                2:       m_route_l = din & 3;
                default: m_route_r = din & 3;
            endcase
        end
`ifndef CDDA_VOL_RAMP_EN
        m_cur_l = m_tgt_l;
        m_cur_r = m_tgt_r;
`endif
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] want [4];
        want[0] = 8'd255; want[1] = 8'd255; want[2] = 8'd1; want[3] = 8'd2;
        nRESET = 1'b0;
        mdl_reset();
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (OUT_CE !== 1'b0 || OUT_L !== 16'd0 || OUT_R !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got ce=%b l=%h r=%h want 0 0000 0000", OUT_CE, OUT_L, OUT_R);
        end
        for (int a = 0; a < 4; a++) begin
            CFG_ADDR = 2'(a);
            #1;
            checks++;
            if (CFG_DOUT !== want[a]) begin
                errors++;
                $display("[TB] FAIL reset_cfg%0d: got %h want %h", a, CFG_DOUT, want[a]);
            end
        end
        @(negedge CLK);
        nRESET = 1'b1;
    endtask

    task automatic test_unity();
        drive(1, 'h1234, 'hF000, 0, 0, 0, 0);
        for (int c = 1; c <= 4; c++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            checks++;
            if (OUT_CE !== (c == 2) || (c >= 2 && (OUT_L !== 16'h1234 || OUT_R !== 16'hF000))) begin
                errors++;
                $display("[TB] FAIL unity cyc%0d: got ce=%b l=%h r=%h want ce=%b l=1234 r=f000",
                         c, OUT_CE, OUT_L, OUT_R, (c == 2));
            end
        end
    endtask

    task automatic test_route();
        drive(0, 0, 0, 1, 2, 'hFF, 0);
        drive(0, 0, 0, 1, 3, 'hFC, 0);
        checks++;
        if (CFG_DOUT !== 8'd0) begin
            errors++;
            $display("[TB] FAIL route_readback: got %h want 00", CFG_DOUT);
        end
        drive(1, -3, 0, 0, 0, 0, 0);
        drive(1, 32767, 32767, 0, 0, 0, 0);
        for (int c = 0; c < 14; c++) begin
            if (c >= 2 && c < 10) drive(1, $urandom_range(0, 65535), $urandom_range(0, 65535), 0, 0, 0, 0);
            else if (c == 10) drive(0, 0, 0, 1, 2 + $urandom_range(0, 1), $urandom_range(0, 255), 0);
            else drive(0, 0, 0, 0, 0, 0, 0);
            checks++;
            if (OUT_CE !== exp_ce || OUT_L !== exp_l || OUT_R !== exp_r) begin
                errors++;
                $display("[TB] FAIL route cyc%0d: got ce=%b l=%h r=%h want ce=%b l=%h r=%h",
                         c, OUT_CE, OUT_L, OUT_R, exp_ce, exp_l, exp_r);
            end
            if (c == 0 || c == 1) begin
                checks++;
                if (OUT_CE !== 1'b1 || OUT_L !== ((c == 0) ? 16'hFFFE : 16'h7FFF) || OUT_R !== 16'd0) begin
                    errors++;
                    $display("[TB] FAIL route_fixed%0d: got ce=%b l=%h r=%h", c, OUT_CE, OUT_L, OUT_R);
                end
            end
        end
        drive(0, 0, 0, 1, 2, 1, 0);
        drive(0, 0, 0, 1, 3, 2, 0);
    endtask

    task automatic test_ramp();
        drive(0, 0, 0, 1, 0, 0, 0);
        checks++;
        if (CFG_DOUT !== 8'd0) begin
            errors++;
            $display("[TB] FAIL ramp_target_read: got %h want 00", CFG_DOUT);
        end
        drive(0, 0, 0, 1, 1, 128, 0);
        for (int c = 0; c < 80; c++) begin
            if (c == 40) drive(1, $urandom_range(0, 65535), $urandom_range(0, 65535), 1, 0, 200, 0);
            else drive(c < 76, $urandom_range(0, 65535), $urandom_range(0, 65535), 0, 0, 0, 0);
            checks++;
            if (OUT_CE !== exp_ce || OUT_L !== exp_l || OUT_R !== exp_r) begin
                errors++;
                $display("[TB] FAIL ramp cyc%0d: got ce=%b l=%h r=%h want ce=%b l=%h r=%h",
                         c, OUT_CE, OUT_L, OUT_R, exp_ce, exp_l, exp_r);
            end
        end
    endtask

    task automatic test_back_to_back();
        int il [3];
        int ir [3];
        int got [$];
        drive(0, 0, 0, 1, 0, 255, 0);
        drive(0, 0, 0, 1, 1, 255, 0);
        for (int c = 0; c < 70; c++) drive(1, $urandom_range(0, 65535), $urandom_range(0, 65535), 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            il[k] = $urandom_range(0, 65535);
            ir[k] = $urandom_range(0, 65535);
        end
        for (int c = 0; c < 6; c++) begin
            if (c < 3) drive(1, il[c], ir[c], c == 1, 2, 'h02, 0);
            else drive(0, 0, 0, 0, 0, 0, 0);
            if (OUT_CE === 1'b1) got.push_back(int'(OUT_L));
            checks++;
            if (OUT_CE !== exp_ce || OUT_L !== exp_l || OUT_R !== exp_r) begin
                errors++;
                $display("[TB] FAIL b2b cyc%0d: got ce=%b l=%h r=%h want ce=%b l=%h r=%h",
                         c, OUT_CE, OUT_L, OUT_R, exp_ce, exp_l, exp_r);
            end
        end
        checks++;
        if (got.size() != 3 || got[0] != il[0] || got[1] != il[1] || got[2] != ir[2]) begin
            errors++;
            $display("[TB] FAIL b2b_order: got %0d outputs, want 3 = %h %h %h", got.size(), il[0], il[1], ir[2]);
        end
        drive(0, 0, 0, 1, 2, 1, 0);
    endtask

    task automatic test_mute();
        for (int c = 0; c < 8; c++) begin
            drive(c == 0 || c == 4, $urandom_range(1, 32767), $urandom_range(1, 32767), 0, 0, 0, c < 3);
            checks++;
            if (OUT_CE !== exp_ce || OUT_L !== exp_l || OUT_R !== exp_r) begin
                errors++;
                $display("[TB] FAIL mute cyc%0d: got ce=%b l=%h r=%h want ce=%b l=%h r=%h",
                         c, OUT_CE, OUT_L, OUT_R, exp_ce, exp_l, exp_r);
            end
            if (c == 2) begin
                checks++;
                if (OUT_CE !== 1'b1 || OUT_L !== 16'd0 || OUT_R !== 16'd0) begin
                    errors++;
                    $display("[TB] FAIL mute_zero: got ce=%b l=%h r=%h want 1 0000 0000", OUT_CE, OUT_L, OUT_R);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            drive($urandom_range(0, 9) < 6, $urandom_range(0, 65535), $urandom_range(0, 65535),
                  $urandom_range(0, 9) < 2, $urandom_range(0, 3), $urandom_range(0, 255), 0);
            checks++;
            if (OUT_CE !== exp_ce || OUT_L !== exp_l || OUT_R !== exp_r || CFG_DOUT !== 8'(m_dout(int'(CFG_ADDR)))) begin
                errors++;
                $display("[TB] FAIL random cyc%0d: got ce=%b l=%h r=%h cfg=%h want ce=%b l=%h r=%h cfg=%h",
                         c, OUT_CE, OUT_L, OUT_R, CFG_DOUT, exp_ce, exp_l, exp_r, 8'(m_dout(int'(CFG_ADDR))));
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 0, 1, 0, 77, 0);
        drive(1, 'h1111, 'h2222, 0, 0, 0, 0);
        drive(1, 'h3333, 'h4444, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (OUT_CE !== 1'b1) begin
            errors++;
            $display("[TB] FAIL resetmid_pre: got ce=%b want 1", OUT_CE);
        end
        #2;
        nRESET = 1'b0;
        #1;
        checks++;
        if (OUT_CE !== 1'b0 || OUT_L !== 16'd0 || OUT_R !== 16'd0) begin
            errors++;
            $display("[TB] FAIL resetmid_async: got ce=%b l=%h r=%h want 0 0000 0000", OUT_CE, OUT_L, OUT_R);
        end
        mdl_reset();
        @(posedge CLK);
        @(negedge CLK);
        nRESET = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            checks++;
            if (OUT_CE !== 1'b0 || OUT_L !== 16'd0 || OUT_R !== 16'd0) begin
                errors++;
                $display("[TB] FAIL resetmid_flush cyc%0d: got ce=%b l=%h r=%h want 0 0000 0000",
                         c, OUT_CE, OUT_L, OUT_R);
            end
        end
        checks++;
        if (CFG_DOUT !== 8'd255) begin
            errors++;
            $display("[TB] FAIL resetmid_vol: got %h want ff", CFG_DOUT);
        end
    endtask

    initial begin
        test_reset();
        test_unity();
        test_route();
        test_ramp();
        test_back_to_back();
        test_mute();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cdda_volume.md
Name: cdda_volume

Overview:
- Output stage directly downstream of the CD-DA sample buffer.
- Consumes its 44.1 kHz stereo stream (CE strobe plus signed 16-bit L/R).
- Applies ATAPI-style port routing (audio control page 0Eh semantics), 8-bit per-output volume with click-free ramping, and mute.
- Hands the result to the SoC audio mixer.

Parameters:
- DEFAULT_VOL, 8'd255, volume target/current for both outputs after reset.
- RAMP_STEP, 8'd4, max change of current volume per input sample; must be ≥1.

Ports:
- CLK  in  1  system clock
- nRESET  in  1  asynchronous active-low reset
- IN_CE  in  1  one-cycle strobe, sample valid on IN_L/IN_R
- IN_L  in  16  signed left sample
- IN_R  in  16  signed right sample
- CFG_WR  in  1  one-cycle config write strobe
- CFG_ADDR  in  2  0=VOL_L, 1=VOL_R, 2=ROUTE_L, 3=ROUTE_R
- CFG_DIN  in  8  write data; ROUTE uses bits [1:0]
- CFG_DOUT  out  8  readback of register at CFG_ADDR (target value for VOL), combinational from registers
- MUTE  in  1  force silence
- OUT_CE  out  1  one-cycle strobe, OUT_L/OUT_R valid
- OUT_L  out  16  signed left result
- OUT_R  out  16  signed right result

Behaviour:
- Clock/reset: single clock CLK; reset nRESET is asynchronous, active-low.
- Reset state: OUT_CE=0, OUT_L=0, OUT_R=0; pipeline valid bits cleared; VOL targets and currents = DEFAULT_VOL; ROUTE_L=2'b01, ROUTE_R=2'b10.
- Reset mid-operation: any in-flight sample is discarded; no OUT_CE is issued for it.
- Pipeline: two stages, fully pipelined; IN_CE may assert on consecutive cycles. IN_CE at edge t gives OUT_CE high for exactly one cycle after edge t+2, with OUT_L/OUT_R updated at that same edge. OUT_L/OUT_R hold their value between strobes.
- Stage 1 (route), per output x, registered on IN_CE:
  - ROUTE_x=00 gives 0.
  - 01 gives IN_L.
  - 10 gives IN_R.
  - 11 gives (sext17(IN_L)+sext17(IN_R))>>>1, arithmetic shift (floor). Example: -3 and 0 give -2.
  - The current volume for x is captured alongside the routed value.
- Stage 2 (gain):
  - Captured volume 255 gives result = routed value (exact unity).
  - Otherwise result = (routed × vol)>>>8, computed as 25-bit signed, arithmetic shift, low 16 bits taken. No overflow is possible.
  - MUTE sampled at stage-2 edge = 1 forces result 0; OUT_CE still pulses.
- Config write:
  - CFG_WR at edge e updates the target (VOL) or the route register at e.
  - An IN_CE at the same edge e uses the old route and old current volume.
  - CFG_DIN[7:2] are ignored for ROUTE writes.
- Volume ramp (with CDDA_VOL_RAMP_EN), per output, on each IN_CE edge after capture:
  - |target−current| ≤ RAMP_STEP: current=target.
  - target>current: current += RAMP_STEP.
  - Otherwise current −= RAMP_STEP.
  - Use 9-bit compare; current never under- or overflows.
  - current changes only on IN_CE, so no drift without input samples.
- Both outputs ramp independently.
- A config write to a volume target mid-ramp retargets from the present current value.

Optional Feature:
- Macro CDDA_VOL_RAMP_EN.
- Defined: ramping as above; RAMP_STEP is used.
- Undefined: current volume equals target immediately. A write at edge e applies to an IN_CE at edge e+1 or later. RAMP_STEP is unused; no ramp logic is synthesized.

Test Plan:
- Reset, then IN_CE with IN_L=16'h1234, IN_R=16'hF000 → OUT_CE exactly 2 cycles later; OUT_L=16'h1234, OUT_R=16'hF000 (unity, default routing).
- ROUTE_L=11, ROUTE_R=00; IN_L=-3, IN_R=0 → OUT_L=-2, OUT_R=0. Then IN_L=32767, IN_R=32767 → OUT_L=32767.
- Ramp build: write VOL_L=0, VOL_R=128 with no IN_CE, then IN_CE → current unchanged, OUT_L=IN_L. Over subsequent IN_CEs current steps 255→251→247…; by the 64th following sample, VOL_L=0 (VOL_R=128 after 32 samples). Non-ramp build: next sample gives OUT_L=0 and OUT_R=(IN_R×128)>>>8.
- IN_CE on 3 consecutive cycles with distinct samples → 3 consecutive OUT_CE cycles, values in order. CFG_WR ROUTE_L=10 on the same edge as the second IN_CE → second output uses old route, third uses IN_R.
- MUTE=1 during a sample → OUT_CE pulses with OUT_L=OUT_R=0. MUTE=0 → next sample normal.
- Assert nRESET low asynchronously one cycle after IN_CE → no OUT_CE. Outputs go 0 immediately; CFG_DOUT for VOL_L reads DEFAULT_VOL after release.
